imem_fetch_ctrl: RTL and testbench

Sequencer for the single-port, 512-word instruction memory, which returns read data one clock after the address. It owns the fetch PC and multiplexes the memory between a boot-time program loader (writes) and the IF stage (reads). It buffers returned words in a 2-entry FIFO and presents them to decode with valid/ready, supporting stalls, branch redirect and halt.

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_fetch_buf.sv | 42 ++++
 rtl/imem_fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory fetch sequencer.
package imem_pkg;
   localparam int          INST_W        = 32;
   localparam int          IMEM_ADDR_W   = 9;
   localparam logic [31:0] IMEM_RESET_PC = 32'h0000_0000;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fetch_state_e;

   typedef struct packed {
      logic [31:0]       pc;
      logic [INST_W-1:0] inst;
   } fetch_ent_t;
endpackage

// File: rtl/imem_fetch_buf.sv
// Two-entry FIFO of {pc, inst} between memory return and decode.
module fetch_buf
   import imem_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  fetch_ent_t push_data,
   input  logic       pop,
   input  logic       flush,
   output fetch_ent_t head,
   output logic [1:0] count
);
   fetch_ent_t ent_q [2];
   logic       rd_ptr, wr_ptr;
   logic       push_ok, pop_ok;

   assign push_ok = push && (count != 2'd2);
   assign pop_ok  = pop && (count != 2'd0);
   assign head    = ent_q[rd_ptr];

   // flush beats a same-cycle push so a killed return never lands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
         for (int i = 0; i < 2; i++) ent_q[i] <= '0;
      end else if (flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) begin
            ent_q[wr_ptr] <= push_data;
            wr_ptr        <= ~wr_ptr;
         end
         if (pop_ok) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: loader writes in IDLE, PC-driven reads in RUN, 2-deep return buffer.
// Optional perf counters under IMEM_FETCH_PERF_EN.
module imem_fetch_ctrl
   import imem_pkg::*;
#(
   parameter int          ADDR_W   = IMEM_ADDR_W,
   parameter logic [31:0] RESET_PC = IMEM_RESET_PC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [31:0]       start_pc,
   input  logic              halt,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [31:0]       ld_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              redir_valid,
   input  logic [31:0]       redir_pc,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [31:0]       if_inst,
   output logic [31:0]       if_pc,
`ifdef IMEM_FETCH_PERF_EN
   output logic              running,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_stall
`else
   output logic              running
`endif
);
   fetch_state_e state;
   logic [31:0]  pc, rd_pc;
   logic [1:0]   occ, cnt;
   logic         kill, rd_vld;
   logic         is_run, pop, issue, flush, push, ld_we;
   fetch_ent_t   head;

   assign is_run = (state == RUN);
   assign pop    = if_valid && if_ready;
   // occ counts in-flight plus buffered words, so the FIFO can never overflow
   assign issue  = is_run && !halt && !redir_valid && ((occ != 2'd2) || pop);
   assign flush  = is_run && (halt || redir_valid);
   assign push   = rd_vld && !kill;
   assign ld_we  = !is_run && ld_valid;

   assign ld_ready  = !is_run;
   assign running   = is_run;
   assign mem_re    = issue;
   assign mem_we    = ld_we;
   assign mem_addr  = ld_we ? ld_addr : (issue ? pc[ADDR_W+1:2] : '0);
   assign mem_wdata = ld_we ? ld_data : '0;
   assign if_valid  = (cnt != 2'd0);
   assign if_inst   = if_valid ? head.inst : '0;
   assign if_pc     = if_valid ? head.pc : '0;

   fetch_buf u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ('{pc: rd_pc, inst: mem_rdata}),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .count     (cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         occ    <= 2'd0;
         kill   <= 1'b0;
         rd_vld <= 1'b0;
         rd_pc  <= '0;
      end else begin
         kill   <= 1'b0;
         rd_vld <= issue;
         rd_pc  <= pc;
         case (state)
            IDLE: if (start) begin
               state <= RUN;
               pc    <= start_pc & ~32'd3;
            end
            RUN: if (halt) begin
               state <= IDLE;
               pc    <= RESET_PC;
               occ   <= 2'd0;
               kill  <= 1'b1;
            end else if (redir_valid) begin
               pc    <= redir_pc & ~32'd3;
               occ   <= 2'd0;
               kill  <= 1'b1;
            end else begin
               if (issue) pc <= pc + 32'd4;
               occ <= occ + {1'b0, issue} - {1'b0, pop};
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef IMEM_FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else if (!is_run && start) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (pop && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
         if (is_run && if_valid && !if_ready && (perf_stall != '1))
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl with a 1-cycle-latency memory model.
module tb_imem_fetch_ctrl;
   localparam int ADDR_W = 9;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0, halt = 1'b0, ld_valid = 1'b0;
   logic              redir_valid = 1'b0, if_ready = 1'b0;
   logic [31:0]       start_pc = '0, redir_pc = '0, ld_data = '0;
   logic [ADDR_W-1:0] ld_addr = '0;
   logic              ld_ready, mem_re, mem_we, if_valid, running;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata, mem_rdata, if_inst, if_pc;
`ifdef IMEM_FETCH_PERF_EN
   logic [31:0]       perf_fetched, perf_stall;
`endif

   imem_fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .halt(halt),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .redir_valid(redir_valid), .redir_pc(redir_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
`ifdef IMEM_FETCH_PERF_EN
      .perf_fetched(perf_fetched), .perf_stall(perf_stall),
`endif
      .running(running)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [512];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
   exp_t q[$];
   int checks = 0, failures = 0, pops = 0;

   function automatic logic [31:0] word_of(input int a);
      case (a)
         0: return 32'h11;
         1: return 32'h22;
         2: return 32'h33;
         3: return 32'h44;
         511: return 32'hDEAD_0511;
         default: return 32'h1000 + a;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst);
      exp_t e;
      e.pc = pc; e.inst = inst;
      q.push_back(e);
   endtask

   // returns 1ns after the posedge following the target pop
   task automatic wait_pops(input int target);
      int b = 0;
      do begin @(posedge clk); b++; end while (pops < target && b < 60);
      if (pops < target) begin
         checks++; failures++;
         $display("FAIL wait_pops got=%0d want=%0d", pops, target);
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && if_valid && if_ready) begin
         pops++;
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_pop got pc=%h inst=%h want none", if_pc, if_inst);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("pop_inst", if_inst, e.inst);
            chk("pop_pc", if_pc, e.pc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_mem_re", {31'b0, mem_re}, 32'd0);
      chk("rst_running", {31'b0, running}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ld_ready", {31'b0, ld_ready}, 32'd1);

      for (int i = 0; i < 25; i++) begin
         int a;
         a = (i == 24) ? 511 : i;
         @(posedge clk); #1;
         ld_valid = 1'b1; ld_addr = a[ADDR_W-1:0]; ld_data = word_of(a);
         if (i == 0 || i == 24) begin
            @(negedge clk);
            chk("ld_we", {31'b0, mem_we}, 32'd1);
            chk("ld_addr", {23'b0, mem_addr}, a);
            chk("ld_wdata", mem_wdata, word_of(a));
         end
      end
      @(posedge clk); #1 ld_valid = 1'b0;

      // stream from 0 with a 5-cycle stall after four pops
      for (int k = 0; k < 8; k++) push_exp(4 * k, word_of(k));
      start = 1'b1; start_pc = 32'h0; if_ready = 1'b1;
      @(negedge clk);
      chk("start_cyc_re", {31'b0, mem_re}, 32'd0);
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("first_re", {31'b0, mem_re}, 32'd1);
      chk("first_addr", {23'b0, mem_addr}, 32'd0);
      chk("run_running", {31'b0, running}, 32'd1);
      chk("run_ld_ready", {31'b0, ld_ready}, 32'd0);
      @(negedge clk);
      chk("lat_if_valid_lo", {31'b0, if_valid}, 32'd0);
      @(negedge clk);
      chk("lat_if_valid_hi", {31'b0, if_valid}, 32'd1);
      wait_pops(4);
      if_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("stall_inst", if_inst, word_of(4));
         chk("stall_pc", if_pc, 32'd16);
         chk("stall_no_re", {31'b0, mem_re}, 32'd0);
      end
      @(posedge clk); #1 if_ready = 1'b1;

      // redirect with word 8 buffered and word 9 in flight
      wait_pops(8);
      for (int k = 16; k < 20; k++) push_exp(4 * k, word_of(k));
      if_ready = 1'b0; redir_valid = 1'b1; redir_pc = 32'h40;
      @(negedge clk);
      chk("redir_no_re", {31'b0, mem_re}, 32'd0);
      @(posedge clk); #1 redir_valid = 1'b0; if_ready = 1'b1;
      @(negedge clk);
      chk("redir_valid_lo1", {31'b0, if_valid}, 32'd0);
      chk("redir_addr", {23'b0, mem_addr}, 32'd16);
      @(negedge clk);
      chk("redir_valid_lo2", {31'b0, if_valid}, 32'd0);
      @(negedge clk);
      chk("redir_valid_hi", {31'b0, if_valid}, 32'd1);
      chk("redir_pc_out", if_pc, 32'h40);

      // halt together with redirect
      wait_pops(12);
      if_ready = 1'b0; halt = 1'b1; redir_valid = 1'b1; redir_pc = 32'h100;
      @(posedge clk); #1 halt = 1'b0; redir_valid = 1'b0; if_ready = 1'b1;
      @(negedge clk);
      chk("halt_ld_ready", {31'b0, ld_ready}, 32'd1);
      chk("halt_running", {31'b0, running}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("halt_no_valid", {31'b0, if_valid}, 32'd0);
      end

      // wrap at the top of memory; low pc bits ignored
      push_exp(32'h7FC, word_of(511));
      push_exp(32'h800, word_of(0));
      @(posedge clk); #1 start = 1'b1; start_pc = 32'h7FF;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("wrap_addr_hi", {23'b0, mem_addr}, 32'd511);
      @(negedge clk);
      chk("wrap_addr_lo", {23'b0, mem_addr}, 32'd0);
      wait_pops(14);
      if_ready = 1'b0; halt = 1'b1;
      @(posedge clk); #1 halt = 1'b0; if_ready = 1'b1;

      // start and loader write in the same cycle
      push_exp(32'h50, 32'hCAFE_0050);
      @(posedge clk); #1;
      start = 1'b1; start_pc = 32'h50;
      ld_valid = 1'b1; ld_addr = 9'd20; ld_data = 32'hCAFE_0050;
      @(negedge clk);
      chk("both_we", {31'b0, mem_we}, 32'd1);
      @(posedge clk); #1 start = 1'b0; ld_valid = 1'b0;
      @(negedge clk);
      chk("both_re", {31'b0, mem_re}, 32'd1);
      chk("both_addr", {23'b0, mem_addr}, 32'd20);
      wait_pops(15);

      // reset mid-RUN with word 22 in flight
      if_ready = 1'b0; rst_n = 1'b0;
      #1;
      chk("arst_if_valid", {31'b0, if_valid}, 32'd0);
      chk("arst_if_inst", if_inst, 32'd0);
      chk("arst_if_pc", if_pc, 32'd0);
      chk("arst_mem_re", {31'b0, mem_re}, 32'd0);
      chk("arst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("arst_mem_addr", {23'b0, mem_addr}, 32'd0);
      chk("arst_mem_wdata", mem_wdata, 32'd0);
      chk("arst_running", {31'b0, running}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; if_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_ld_ready", {31'b0, ld_ready}, 32'd1);
      chk("post_rst_running", {31'b0, running}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_no_valid", {31'b0, if_valid}, 32'd0);
      end
      chk("sb_drained", q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
